// File: rtl/nn_multiplier.sv
// Nearest-neighbour address scaler: p = round(a * b), b in unsigned 1.FRAC fixed point.
// Three register ranks (input, rounded product, saturated output) give two cycles from sample to result.
module nn_multiplier #(
   parameter int A_W  = 12,
   parameter int B_W  = 17,
   parameter int FRAC = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [A_W-1:0] a,
   input  logic [B_W-1:0] b,
   input  logic           valid_in,
   output logic [A_W-1:0] p,
   output logic           valid_out,
   output logic           overflow
);

   localparam int PROD_W = A_W + B_W;
   // One spare bit above the product so adding the rounding half can never wrap.
   localparam int SUM_W  = PROD_W + 1;
   localparam int RES_W  = SUM_W - FRAC;
   localparam logic [SUM_W-1:0] HALF = SUM_W'(1) << (FRAC - 1);

   logic [A_W-1:0]   a_q;
   logic [B_W-1:0]   b_q;
   logic             v1_q;
   logic [RES_W-1:0] rnd_q;
   logic             v2_q;

   logic [SUM_W-1:0] sum_c;
   logic [RES_W-1:0] rnd_c;
   logic             sat_c;

   assign sum_c = (SUM_W'(a_q) * SUM_W'(b_q)) + HALF;
   assign rnd_c = RES_W'(sum_c >> FRAC);
   assign sat_c = |rnd_q[RES_W-1:A_W];

   // NOTE: every register below is assigned with <= so all ranks see the
   // pre-edge values of their predecessors; blocking '=' here would collapse
   // the pipeline into fewer stages.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q       <= '0;
         b_q       <= '0;
         v1_q      <= 1'b0;
         rnd_q     <= '0;
         v2_q      <= 1'b0;
         p         <= '0;
         overflow  <= 1'b0;
         valid_out <= 1'b0;
      end else begin
         a_q       <= a;
         b_q       <= b;
         v1_q      <= valid_in;
         rnd_q     <= rnd_c;
         v2_q      <= v1_q;
         p         <= sat_c ? {A_W{1'b1}} : rnd_q[A_W-1:0];
         overflow  <= sat_c;
         valid_out <= v2_q;
      end
   end

endmodule

// File: tb/tb_nn_multiplier.sv
// Self-checking bench for nn_multiplier: directed cases plus random traffic
// compared against an arithmetic reference with a two-cycle delay queue.
module tb_nn_multiplier;

   logic        clk;
   logic        reset;
   logic [11:0] a;
   logic [16:0] b;
   logic        valid_in;
   logic [11:0] p;
   logic        valid_out;
   logic        overflow;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        v;
      logic [11:0] p;
      logic        o;
   } exp_t;

   exp_t q[$];
   exp_t zero_e = '{v: 1'b0, p: 12'h000, o: 1'b0};

   nn_multiplier #(.A_W(12), .B_W(17), .FRAC(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .a         (a),
      .b         (b),
      .valid_in  (valid_in),
      .p         (p),
      .valid_out (valid_out),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: real-valued a*b/65536 rounded half-up, saturated to 12 bits.
   function automatic exp_t ref_out(input logic vi, input logic [11:0] ai, input logic [16:0] bi);
      exp_t e;
      longint unsigned r;
      r = (longint'(ai) * longint'(bi) + 64'd32768) / 64'd65536;
      e.v = vi;
      if (r > 64'd4095) begin
         e.p = 12'hFFF;
         e.o = 1'b1;
      end else begin
         e.p = 12'(r);
         e.o = 1'b0;
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, then compare #1 after the edge.
   task automatic step(input string tag, input logic [11:0] ai, input logic [16:0] bi,
                       input logic vi, input logic ri);
      exp_t e;
      a        = ai;
      b        = bi;
      valid_in = vi;
      reset    = ri;
      @(posedge clk);
      if (ri) begin
         q = '{zero_e, zero_e, zero_e};
      end else begin
         q.push_back(ref_out(vi, ai, bi));
         void'(q.pop_front());
      end
      e = q[0];
      #1;
      check({tag, ".valid_out"}, 32'(valid_out), 32'(e.v));
      check({tag, ".p"},         32'(p),         32'(e.p));
      check({tag, ".overflow"},  32'(overflow),  32'(e.o));
   endtask

   task automatic flush(input string tag);
      for (int i = 0; i < 3; i++) step(tag, 12'h000, 17'h00000, 1'b0, 1'b0);
   endtask

   initial begin
      a        = '0;
      b        = '0;
      valid_in = 1'b0;
      reset    = 1'b1;
      q        = '{zero_e, zero_e, zero_e};

      // Reset state, with valid_in high to show reset wins.
      step("reset0", 12'h123, 17'h10000, 1'b1, 1'b1);
      step("reset1", 12'h456, 17'h10000, 1'b1, 1'b1);

      // Identity sweep.
      for (int i = 0; i <= 12'h7FE; i++)
         step("identity", 12'(i), 17'h10000, 1'b1, 1'b0);
      flush("identity_tail");

      // Half scale with tie rounding.
      step("half_a4",   12'h004, 17'h08000, 1'b1, 1'b0);
      step("half_a5",   12'h005, 17'h08000, 1'b1, 1'b0);
      step("half_a7fe", 12'h7FE, 17'h08000, 1'b1, 1'b0);
      flush("half_tail");

      // 1.5 scale, including saturation and the exact-max edge.
      step("x15_a3",    12'h003, 17'h18000, 1'b1, 1'b0);
      step("x15_a7fe",  12'h7FE, 17'h18000, 1'b1, 1'b0);
      step("x15_afff",  12'hFFF, 17'h18000, 1'b1, 1'b0);
      step("x15_aaaa",  12'hAAA, 17'h18000, 1'b1, 1'b0);
      step("x15_aaab",  12'hAAB, 17'h18000, 1'b1, 1'b0);
      flush("x15_tail");

      // Zero operands.
      step("b0_afff",   12'hFFF, 17'h00000, 1'b1, 1'b0);
      step("a0_bmax",   12'h000, 17'h1FFFF, 1'b1, 1'b0);
      step("max_max",   12'hFFF, 17'h1FFFF, 1'b1, 1'b0);
      flush("zero_tail");

      // valid_in toggling 1,0,1.
      step("tog1", 12'h100, 17'h0C000, 1'b1, 1'b0);
      step("tog0", 12'h200, 17'h0C000, 1'b0, 1'b0);
      step("tog2", 12'h300, 17'h0C000, 1'b1, 1'b0);
      flush("tog_tail");

      // Reset one cycle after a valid op: the op must never surface.
      step("inflight_op",  12'h7FF, 17'h18000, 1'b1, 1'b0);
      step("inflight_rst", 12'h000, 17'h00000, 1'b0, 1'b1);
      flush("inflight_tail");

      // Reset right after a back-to-back pair, then first post-reset sample.
      step("pair0", 12'hFFF, 17'h1FFFF, 1'b1, 1'b0);
      step("pair1", 12'h555, 17'h13333, 1'b1, 1'b0);
      step("pair_rst", 12'h000, 17'h00000, 1'b1, 1'b1);
      step("post_rst", 12'h0F0, 17'h10000, 1'b1, 1'b0);
      flush("post_rst_tail");

      // Random traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         step("rand",
              12'($urandom_range(0, 12'hFFF)),
              17'($urandom_range(0, 17'h1FFFF)),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 19) == 0));
      end
      flush("rand_tail");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/nn_multiplier.md
NN_MULTIPLIER -- requirements
Module: nn_multiplier

Interface
REQ-001 Parameter A_W, default 12: width of operand a and result p.
REQ-002 Parameter B_W, default 17: width of scale factor b.
REQ-003 Parameter FRAC, default 16: fraction bits of b (unsigned 1.16 fixed point).
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 Port a, input, A_W: unsigned base address/index.
REQ-007 Port b, input, B_W: unsigned scale factor, 1 integer bit + 16 fraction bits (0x10000 = 1.0, 0x8000 = 0.5, 0x18000 = 1.5).
REQ-008 Port valid_in, input, 1: qualifies a/b in the same cycle.
REQ-009 Port p, output, A_W, registered: nearest-neighbour scaled address round(a*b).
REQ-010 Port valid_out, output, 1, registered: p/overflow are valid this cycle.
REQ-011 Port overflow, output, 1, registered: the exact rounded result exceeded 2^A_W-1 and p is saturated.

Function
REQ-012 Sampling: a, b and valid_in SHALL be registered on every rising edge of clk; no combinational path from input to output.
REQ-013 Product: full-precision unsigned product a*b, A_W+B_W = 29 bits, no truncation before rounding.
REQ-014 Rounding: result = (a*b + 2^(FRAC-1)) >> FRAC, i.e. round to nearest with ties rounded up.
REQ-015 Width: the rounded result is up to 13 bits; if it is greater than 2^A_W-1, p = all ones (0xFFF) and overflow = 1, otherwise p = result and overflow = 0.
REQ-016 Latency: exactly 2 clock cycles; inputs sampled on edge N produce p/valid_out/overflow visible after edge N+2.
REQ-017 Throughput: one new operand pair accepted every cycle; fully pipelined; no backpressure or stall.
REQ-018 valid_out is valid_in delayed by 2 cycles; p and overflow are still computed and updated when valid_in = 0, but only carry meaning while valid_out = 1.
REQ-019 b = 0 gives p = 0 and overflow = 0 for any a; a = 0 gives p = 0 for any b.
REQ-020 b = 0x10000 gives p = a exactly for all a (identity), with no rounding effect.
REQ-021 Result is independent of input history; no accumulation or state beyond the pipeline registers.

Reset
REQ-022 While reset = 1 at a rising edge, all pipeline registers clear, including both stages: p = 0, valid_out = 0, overflow = 0 after that edge.
REQ-023 Reset has priority over valid_in. Operations in flight when reset is asserted are discarded and never produce valid_out.
REQ-024 Inputs sampled on the first edge with reset = 0 produce valid_out = 1 (if valid_in = 1) two edges later.

Verification
REQ-025 b=0x10000, sweep a=0..0x7FE with valid_in=1 every cycle -> p equals a each cycle, 2-cycle delayed, overflow=0.
REQ-026 b=0x08000 -> a=4 gives p=2; a=5 gives p=3 (tie rounds up); a=0x7FE gives p=0x3FF.
REQ-027 b=0x18000 -> a=3 gives p=5 (4.5 rounds up); a=0x7FE gives p=0xBFD; overflow=0.
REQ-028 a=0xFFF, b=0x18000 -> p=0xFFF, overflow=1; a=0xAAA, b=0x18000 (exact 4095) -> p=0xFFF, overflow=0.
REQ-029 Back-to-back stream with valid_in toggling 1,0,1 -> valid_out follows as 1,0,1 two cycles later, with correct p on each valid cycle.
REQ-030 Assert reset one cycle after issuing a valid operation -> valid_out, p and overflow all stay 0, and the in-flight result never appears.
